// File: rtl/trig_cap_sched.sv
// Capture scheduler: issues one-hot CE pulses LSB-first over a masked bank with a GAP-cycle idle between pulses.
// Optional shadow of captured bank contents on ODATA when TRIG_CAP_SCHED_SHADOW_EN is defined.
module trig_cap_sched #(
    parameter int unsigned N   = 4,
    parameter int unsigned GAP = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ,
    input  logic [N-1:0] MASK,
    input  logic [N-1:0] IDATA,
    output logic         ACK,
    output logic         BUSY,
    output logic [N-1:0] CE,
    output logic         DONE,
    output logic [N-1:0] ODATA
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GAP, S_FIN} state_t;

    localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t       r_state, w_state_nxt;
    logic [N-1:0] r_pend, w_pend_nxt, w_low;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic         r_ack, r_busy, r_done;
    logic [N-1:0] r_ce;
    logic         w_accept, w_ack_nxt, w_busy_nxt, w_done_nxt;
    logic [N-1:0] w_ce_nxt;

    // BUSY is still high in the DONE cycle, so a REQ there is dropped rather than queued.
    assign w_accept = (r_state == S_IDLE) && !r_busy && REQ;
    assign w_low    = r_pend & (~r_pend + 1'b1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ce    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ce    <= w_ce_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_pend_nxt  = MASK;
                    w_state_nxt = (MASK != '0) ? S_SCAN : S_FIN;
                end
            end
            S_SCAN: begin
                w_pend_nxt = r_pend & ~w_low;
                if (w_pend_nxt == '0) begin
                    w_state_nxt = S_FIN;
                end else if (GAP > 0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_LD;
                end else begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_SCAN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack_nxt  = w_accept;
        w_busy_nxt = w_accept || (r_state != S_IDLE);
        w_done_nxt = (r_state == S_FIN);
        w_ce_nxt   = (r_state == S_SCAN) ? w_low : '0;
    end

    assign ACK  = r_ack;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign CE   = r_ce;

`ifdef TRIG_CAP_SCHED_SHADOW_EN
    logic [N-1:0] r_odata;

    // Bit b is sampled on the edge that ends its CE pulse, matching the bank cell's capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_odata <= '0;
        end else begin
            r_odata <= (r_odata & ~r_ce) | (IDATA & r_ce);
        end
    end

    assign ODATA = r_odata;
`else
    logic w_unused_idata;

    assign w_unused_idata = ^IDATA;
    assign ODATA          = '0;
`endif

endmodule

// File: tb/tb_trig_cap_sched.sv
// Directed self-checking bench for trig_cap_sched; one instance with GAP=0 and one with GAP=2.
// ODATA expectations follow TRIG_CAP_SCHED_SHADOW_EN.
module tb_trig_cap_sched;

    logic       CLK = 1'b0;
    logic       RST;
    logic       req0, req2;
    logic [3:0] mask0, mask2, idata;
    logic       ack0, busy0, done0, ack2, busy2, done2;
    logic [3:0] ce0, od0, ce2, od2;
    int         passes = 0;
    int         total  = 0;

`ifdef TRIG_CAP_SCHED_SHADOW_EN
    localparam logic [3:0] EXP_OD_A = 4'hA;
    localparam logic [3:0] EXP_OD_B = 4'hB;
`else
    localparam logic [3:0] EXP_OD_A = 4'h0;
    localparam logic [3:0] EXP_OD_B = 4'h0;
`endif

    always #5 CLK = ~CLK;

    trig_cap_sched #(.N(4), .GAP(0)) u0 (
        .CLK(CLK), .RST(RST), .REQ(req0), .MASK(mask0), .IDATA(idata),
        .ACK(ack0), .BUSY(busy0), .CE(ce0), .DONE(done0), .ODATA(od0)
    );

    trig_cap_sched #(.N(4), .GAP(2)) u2 (
        .CLK(CLK), .RST(RST), .REQ(req2), .MASK(mask2), .IDATA(idata),
        .ACK(ack2), .BUSY(busy2), .CE(ce2), .DONE(done2), .ODATA(od2)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Packs {ACK,BUSY,DONE,CE} of the GAP=0 instance for compact status checks.
    function automatic logic [6:0] st0();
        return {ack0, busy0, done0, ce0};
    endfunction

    function automatic logic [6:0] st2();
        return {ack2, busy2, done2, ce2};
    endfunction

    initial begin
        RST = 1'b1; req0 = 1'b1; req2 = 1'b1; mask0 = 4'hF; mask2 = 4'hF; idata = 4'h0;
        // Reset held with REQ asserted
        tick();
        check("rst1_u0", {st0(), od0}, 11'h0);
        check("rst1_u2", {st2(), od2}, 11'h0);
        tick();
        check("rst2_u0", {st0(), od0}, 11'h0);
        check("rst2_u2", {st2(), od2}, 11'h0);
        RST = 1'b0; req0 = 1'b0; req2 = 1'b0;
        tick();
        check("idle_u0", st0(), 7'h00);

        // GAP=0, MASK=1011
        mask0 = 4'b1011; req0 = 1'b1;
        tick(); req0 = 1'b0; mask0 = 4'b0100;
        check("g0_t1", st0(), {1'b1, 1'b1, 1'b0, 4'b0000});
        tick(); check("g0_t2", st0(), {1'b0, 1'b1, 1'b0, 4'b0001});
        tick(); check("g0_t3", st0(), {1'b0, 1'b1, 1'b0, 4'b0010});
        tick(); check("g0_t4", st0(), {1'b0, 1'b1, 1'b0, 4'b1000});
        tick(); check("g0_t5", st0(), {1'b0, 1'b1, 1'b1, 4'b0000});
        tick(); check("g0_t6", st0(), 7'h00);

        // GAP=2, MASK=0110
        mask2 = 4'b0110; req2 = 1'b1;
        tick(); req2 = 1'b0;
        check("g2_t1", st2(), {1'b1, 1'b1, 1'b0, 4'b0000});
        tick(); check("g2_t2", st2(), {1'b0, 1'b1, 1'b0, 4'b0010});
        tick(); check("g2_t3", st2(), {1'b0, 1'b1, 1'b0, 4'b0000});
        tick(); check("g2_t4", st2(), {1'b0, 1'b1, 1'b0, 4'b0000});
        tick(); check("g2_t5", st2(), {1'b0, 1'b1, 1'b0, 4'b0100});
        tick(); check("g2_t6", st2(), {1'b0, 1'b1, 1'b1, 4'b0000});
        tick(); check("g2_t7", st2(), 7'h00);

        // MASK=0 with REQ held through BUSY and the DONE cycle
        mask0 = 4'b0000; req0 = 1'b1;
        tick(); check("m0_t1", st0(), {1'b1, 1'b1, 1'b0, 4'b0000});
        tick(); check("m0_t2", st0(), {1'b0, 1'b1, 1'b1, 4'b0000});
        tick(); check("m0_t3", st0(), 7'h00);
        tick(); check("m0_t4_reack", st0(), {1'b1, 1'b1, 1'b0, 4'b0000});
        req0 = 1'b0;
        tick(); check("m0_t5", st0(), {1'b0, 1'b1, 1'b1, 4'b0000});
        tick(); check("m0_t6", st0(), 7'h00);

        // Reset mid-run aborts without DONE
        mask0 = 4'hF; req0 = 1'b1;
        tick(); req0 = 1'b0;
        tick(); check("ab_t2", st0(), {1'b0, 1'b1, 1'b0, 4'b0001});
        RST = 1'b1;
        tick(); check("ab_t4", st0(), 7'h00);
        RST = 1'b0;
        tick(); check("ab_t5", st0(), 7'h00);
        tick(); check("ab_t6", st0(), 7'h00);

        // Fresh request after abort
        mask0 = 4'b0011; req0 = 1'b1;
        tick(); req0 = 1'b0;
        check("fr_t1", st0(), {1'b1, 1'b1, 1'b0, 4'b0000});
        tick(); check("fr_t2", st0(), {1'b0, 1'b1, 1'b0, 4'b0001});
        tick(); check("fr_t3", st0(), {1'b0, 1'b1, 1'b0, 4'b0010});
        tick(); check("fr_t4", st0(), {1'b0, 1'b1, 1'b1, 4'b0000});
        tick(); check("fr_t5", st0(), 7'h00);
        check("od_pre", od0, 4'h0);

        // Shadow capture: IDATA=A over all bits, then bit 0 only with IDATA=5
        idata = 4'hA; mask0 = 4'hF; req0 = 1'b1;
        tick(); req0 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("sh_done", done0, 1'b1);
        check("sh_odA", od0, EXP_OD_A);
        tick();
        idata = 4'h5; mask0 = 4'b0001; req0 = 1'b1;
        tick(); req0 = 1'b0;
        tick(); check("sh_ce0", ce0, 4'b0001);
        tick(); check("sh_done2", done0, 1'b1);
        check("sh_odB", od0, EXP_OD_B);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
